pw_capture_ctrl: RTL and testbench

- Capture sequencer in the fe_clk domain, placed between the register block, the pattern matcher and the front-end capture logic.
- Arms the capture, waits for a pattern match or a forced start, waits a programmable delay, then enables capture for a programmed number of FIFO writes.
- Terminates the capture and reports done, overflow and write count back to the registers.

---
 rtl/pw_capture_ctrl.sv | 135 +++++++++++++
 tb/tb_pw_capture_ctrl.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pw_capture_ctrl.sv
// Capture sequencer: arm, wait for a start event, delay, then gate
// front-end capture for a programmed number of FIFO writes.
module pw_capture_ctrl #(
  parameter int pDELAY_WIDTH = 20,
  parameter int pLEN_WIDTH   = 16
) (
  input  logic                    fe_clk,
  input  logic                    reset_i,
  input  logic                    I_arm,
  input  logic                    I_capture_now,
  input  logic                    I_match,
  input  logic [pDELAY_WIDTH-1:0] I_capture_delay,
  input  logic [pLEN_WIDTH-1:0]   I_capture_len,
  input  logic                    I_data_wr,
  input  logic                    I_fifo_full,
  output logic                    O_capture_enable,
  output logic                    O_capturing,
  output logic                    O_done,
  output logic                    O_overflow,
  output logic [pLEN_WIDTH-1:0]   O_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARMED,
    S_DELAY,
    S_CAPTURE,
    S_DONE
  } state_t;

  localparam logic [pDELAY_WIDTH-1:0] DLY_ONE =
    {{(pDELAY_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [pLEN_WIDTH-1:0] LEN_ONE =
    {{(pLEN_WIDTH-1){1'b0}}, 1'b1};

  state_t                  state, state_n;
  logic                    arm_q;
  logic [pDELAY_WIDTH-1:0] dly_r, dly_n;
  logic [pLEN_WIDTH-1:0]   len_r, len_n;
  logic [pLEN_WIDTH-1:0]   count_n, cnt_inc;
  logic                    done_n, ovf_n;
  logic                    arm_rise;

  // arm_q resets high so a level held through reset is not an arm edge
  assign arm_rise = I_arm & ~arm_q;
  assign cnt_inc  = (O_count == '1) ? O_count : O_count + LEN_ONE;

  // State, counters and registered outputs
  always_ff @(posedge fe_clk or posedge reset_i) begin
    if (reset_i) begin
      state            <= S_IDLE;
      arm_q            <= 1'b1;
      dly_r            <= '0;
      len_r            <= '0;
      O_count          <= '0;
      O_done           <= 1'b0;
      O_overflow       <= 1'b0;
      O_capture_enable <= 1'b0;
      O_capturing      <= 1'b0;
    end else begin
      state            <= state_n;
      arm_q            <= I_arm;
      dly_r            <= dly_n;
      len_r            <= len_n;
      O_count          <= count_n;
      O_done           <= done_n;
      O_overflow       <= ovf_n;
      O_capture_enable <= (state_n == S_CAPTURE);
      O_capturing      <= (state_n == S_DELAY) |
                          (state_n == S_CAPTURE);
    end
  end

  // Next-state and next-value logic; disarm aborts any active phase
  always_comb begin
    state_n = state;
    dly_n   = dly_r;
    len_n   = len_r;
    count_n = O_count;
    done_n  = O_done;
    ovf_n   = O_overflow;
    unique case (state)
      S_IDLE: begin
        if (arm_rise) begin
          state_n = S_ARMED;
          len_n   = I_capture_len;
          count_n = '0;
          done_n  = 1'b0;
          ovf_n   = 1'b0;
        end
      end
      S_ARMED: begin
        if (!I_arm) begin
          state_n = S_IDLE;
        end else if (I_match | I_capture_now) begin
          dly_n   = I_capture_delay;
          state_n = (I_capture_delay == '0) ? S_CAPTURE : S_DELAY;
        end
      end
      S_DELAY: begin
        dly_n = dly_r - DLY_ONE;
        if (!I_arm) begin
          state_n = S_IDLE;
        end else if (dly_r == DLY_ONE) begin
          state_n = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        if (I_data_wr) begin
          count_n = cnt_inc;
        end
        if (!I_arm) begin
          state_n = S_IDLE;
        end else if (I_data_wr && len_r != '0 && cnt_inc == len_r) begin
          state_n = S_DONE;
          done_n  = 1'b1;
          ovf_n   = 1'b0;
        end else if (I_fifo_full) begin
          state_n = S_DONE;
          done_n  = 1'b1;
          ovf_n   = 1'b1;
        end
      end
      S_DONE: begin
        if (!I_arm) begin
          state_n = S_IDLE;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_pw_capture_ctrl.sv
// Bench for pw_capture_ctrl: per-scenario tasks with inline checks,
// plus a scoreboard of expected end-of-capture results.
module tb_pw_capture_ctrl;

  localparam int DW = 20;
  localparam int LW = 16;

  typedef struct packed {
    logic [LW-1:0] count;
    logic          ovf;
  } exp_t;

  logic          fe_clk = 1'b0;
  logic          reset_i = 1'b1;
  logic          I_arm = 1'b0;
  logic          I_capture_now = 1'b0;
  logic          I_match = 1'b0;
  logic [DW-1:0] I_capture_delay = '0;
  logic [LW-1:0] I_capture_len = '0;
  logic          I_data_wr = 1'b0;
  logic          I_fifo_full = 1'b0;
  logic          O_capture_enable;
  logic          O_capturing;
  logic          O_done;
  logic          O_overflow;
  logic [LW-1:0] O_count;

  int   n_tests = 0;
  int   n_fail = 0;
  exp_t exp_q[$];
  logic done_prev = 1'b0;

  pw_capture_ctrl #(
    .pDELAY_WIDTH(DW),
    .pLEN_WIDTH(LW)
  ) dut (
    .fe_clk(fe_clk),
    .reset_i(reset_i),
    .I_arm(I_arm),
    .I_capture_now(I_capture_now),
    .I_match(I_match),
    .I_capture_delay(I_capture_delay),
    .I_capture_len(I_capture_len),
    .I_data_wr(I_data_wr),
    .I_fifo_full(I_fifo_full),
    .O_capture_enable(O_capture_enable),
    .O_capturing(O_capturing),
    .O_done(O_done),
    .O_overflow(O_overflow),
    .O_count(O_count)
  );

  always #5 fe_clk = ~fe_clk;

  // Scoreboard: each rising O_done retires one expected result
  always @(negedge fe_clk) begin
    if (O_done === 1'b1 && !done_prev) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected_done count=%0d ovf=%0b", O_count, O_overflow);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (O_count !== e.count || O_overflow !== e.ovf) begin
          n_fail++;
          $display("FAIL sb_result got count=%0d ovf=%0b want count=%0d ovf=%0b",
                   O_count, O_overflow, e.count, e.ovf);
        end
      end
    end
    done_prev = (O_done === 1'b1);
  end

  task automatic tick();
    @(posedge fe_clk);
    #1;
  endtask

  task automatic test_reset();
    reset_i = 1'b1;
    tick();
    tick();
    n_tests++;
    if ({O_capture_enable, O_capturing, O_done, O_overflow} !== 4'b0 || O_count !== '0) begin
      n_fail++;
      $display("FAIL reset_state got en=%0b cap=%0b done=%0b ovf=%0b cnt=%0d want all 0",
               O_capture_enable, O_capturing, O_done, O_overflow, O_count);
    end
    reset_i = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    I_capture_len = 16'd4;
    I_capture_delay = '0;
    I_arm = 1'b1;
    tick();
    I_match = 1'b1;
    tick();
    I_match = 1'b0;
    n_tests++;
    if (O_capture_enable !== 1'b1 || O_capturing !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_enable got en=%0b cap=%0b want 1 1", O_capture_enable, O_capturing);
    end
    exp_q.push_back('{count: 16'd4, ovf: 1'b0});
    I_data_wr = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      n_tests++;
      if (O_done !== (i == 4) || O_capture_enable !== (i != 4)) begin
        n_fail++;
        $display("FAIL basic_write%0d got done=%0b en=%0b want done=%0b en=%0b",
                 i, O_done, O_capture_enable, i == 4, i != 4);
      end
    end
    I_data_wr = 1'b0;
    I_arm = 1'b0;
    tick();
    n_tests++;
    if (O_done !== 1'b1 || O_count !== 16'd4) begin
      n_fail++;
      $display("FAIL basic_hold got done=%0b cnt=%0d want 1 4", O_done, O_count);
    end
  endtask

  task automatic test_delay();
    I_capture_len = '0;
    I_capture_delay = 20'd5;
    I_arm = 1'b1;
    tick();
    n_tests++;
    if (O_done !== 1'b0 || O_count !== '0) begin
      n_fail++;
      $display("FAIL delay_arm_clear got done=%0b cnt=%0d want 0 0", O_done, O_count);
    end
    I_capture_now = 1'b1;
    tick();
    I_capture_now = 1'b0;
    n_tests++;
    if (O_capturing !== 1'b1 || O_capture_enable !== 1'b0) begin
      n_fail++;
      $display("FAIL delay_start got cap=%0b en=%0b want 1 0", O_capturing, O_capture_enable);
    end
    for (int i = 2; i <= 6; i++) begin
      tick();
      n_tests++;
      if (O_capture_enable !== (i == 6) || O_capturing !== 1'b1) begin
        n_fail++;
        $display("FAIL delay_t%0d got en=%0b cap=%0b want en=%0b cap=1",
                 i, O_capture_enable, O_capturing, i == 6);
      end
    end
    exp_q.push_back('{count: 16'd0, ovf: 1'b1});
    I_fifo_full = 1'b1;
    tick();
    I_fifo_full = 1'b0;
    I_arm = 1'b0;
    tick();
  endtask

  task automatic test_overflow();
    I_capture_delay = '0;
    for (int pass = 0; pass < 2; pass++) begin
      I_capture_len = (pass == 0) ? 16'd0 : 16'd10;
      I_arm = 1'b1;
      tick();
      I_match = 1'b1;
      tick();
      I_match = 1'b0;
      exp_q.push_back('{count: 16'd10, ovf: (pass == 0)});
      I_data_wr = 1'b1;
      for (int i = 0; i < 9; i++) tick();
      if (pass == 0) begin
        tick();
        I_data_wr = 1'b0;
      end
      I_fifo_full = 1'b1;
      tick();
      I_data_wr = 1'b0;
      I_fifo_full = 1'b0;
      n_tests++;
      if (O_done !== 1'b1 || O_count !== 16'd10 || O_overflow !== (pass == 0)) begin
        n_fail++;
        $display("FAIL overflow_p%0d got done=%0b cnt=%0d ovf=%0b want 1 10 %0b",
                 pass, O_done, O_count, O_overflow, pass == 0);
      end
      I_arm = 1'b0;
      tick();
    end
  endtask

  task automatic test_abort();
    I_capture_len = '0;
    I_capture_delay = 20'd3;
    I_arm = 1'b1;
    tick();
    I_match = 1'b1;
    tick();
    I_match = 1'b0;
    I_arm = 1'b0;
    tick();
    n_tests++;
    if (O_capturing !== 1'b0 || O_capture_enable !== 1'b0 || O_done !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_delay got cap=%0b en=%0b done=%0b want 0 0 0",
               O_capturing, O_capture_enable, O_done);
    end
    I_capture_delay = '0;
    I_arm = 1'b1;
    tick();
    I_match = 1'b1;
    tick();
    I_match = 1'b0;
    I_data_wr = 1'b1;
    tick();
    tick();
    I_data_wr = 1'b0;
    I_arm = 1'b0;
    tick();
    n_tests++;
    if (O_capture_enable !== 1'b0 || O_done !== 1'b0 || O_count !== 16'd2) begin
      n_fail++;
      $display("FAIL abort_capture got en=%0b done=%0b cnt=%0d want 0 0 2",
               O_capture_enable, O_done, O_count);
    end
    I_match = 1'b1;
    tick();
    I_match = 1'b0;
    tick();
    n_tests++;
    if (O_capture_enable !== 1'b0 || O_capturing !== 1'b0 || O_count !== 16'd2) begin
      n_fail++;
      $display("FAIL abort_ignore_match got en=%0b cap=%0b cnt=%0d want 0 0 2",
               O_capture_enable, O_capturing, O_count);
    end
  endtask

  task automatic test_async_reset();
    I_capture_len = 16'd3;
    I_capture_delay = '0;
    I_arm = 1'b1;
    tick();
    I_match = 1'b1;
    tick();
    I_match = 1'b0;
    I_data_wr = 1'b1;
    tick();
    I_data_wr = 1'b0;
    #2 reset_i = 1'b1;
    #1;
    n_tests++;
    if ({O_capture_enable, O_capturing, O_done, O_overflow} !== 4'b0 || O_count !== '0) begin
      n_fail++;
      $display("FAIL async_reset got en=%0b cap=%0b done=%0b ovf=%0b cnt=%0d want all 0",
               O_capture_enable, O_capturing, O_done, O_overflow, O_count);
    end
    @(posedge fe_clk);
    #2 reset_i = 1'b0;
    tick();
    I_match = 1'b1;
    tick();
    I_match = 1'b0;
    tick();
    n_tests++;
    if (O_capture_enable !== 1'b0 || O_capturing !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_no_rearm got en=%0b cap=%0b want 0 0", O_capture_enable, O_capturing);
    end
    I_capture_len = 16'd1;
    I_arm = 1'b0;
    tick();
    I_arm = 1'b1;
    tick();
    I_match = 1'b1;
    tick();
    I_match = 1'b0;
    n_tests++;
    if (O_capture_enable !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_rearm got en=%0b want 1", O_capture_enable);
    end
    exp_q.push_back('{count: 16'd1, ovf: 1'b0});
    I_data_wr = 1'b1;
    tick();
    I_data_wr = 1'b0;
    tick();
    n_tests++;
    if (O_done !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_rearm_done got done=%0b want 1", O_done);
    end
    I_arm = 1'b0;
    tick();
  endtask

  task automatic test_len_change();
    I_capture_len = 16'd4;
    I_capture_delay = '0;
    I_arm = 1'b1;
    tick();
    I_capture_len = 16'd2;
    I_data_wr = 1'b1;
    tick();
    I_data_wr = 1'b0;
    I_match = 1'b1;
    tick();
    I_match = 1'b0;
    n_tests++;
    if (O_count !== 16'd0) begin
      n_fail++;
      $display("FAIL len_armed_write got cnt=%0d want 0", O_count);
    end
    exp_q.push_back('{count: 16'd4, ovf: 1'b0});
    I_data_wr = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      n_tests++;
      if (O_done !== (i == 4) || O_count !== 16'(i)) begin
        n_fail++;
        $display("FAIL len_write%0d got done=%0b cnt=%0d want %0b %0d",
                 i, O_done, O_count, i == 4, i);
      end
    end
    I_data_wr = 1'b0;
    I_arm = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_delay();
    test_overflow();
    test_abort();
    test_async_reset();
    test_len_change();
    tick();
    tick();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_pending got %0d outstanding want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
